// File: rtl/shift_frame_ctrl_pkg.sv
// Shared definitions for the neural-network front end: frame controller state encoding.
package shift_frame_ctrl_pkg;

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  localparam int FILL_W = 4;
  localparam int CNT_W  = 8;

  // Fill count that remains after a frame is consumed; a sliding window keeps all but the oldest tap.
  function automatic logic [FILL_W-1:0] fill_after_ack(input int depth, input int slide);
    fill_after_ack = (slide != 0) ? FILL_W'(depth - 1) : '0;
  endfunction

endpackage

// File: rtl/shift_frame_ctrl.sv
// Sequences samples into an external tap shift register and flags when a full frame is available.
// Zero-latency shift enable; in_ready drops while the frame is full, clearing, or being flushed.
module shift_frame_ctrl
  import shift_frame_ctrl_pkg::*;
#(
  parameter int Width = 10,
  parameter int Depth = 10,
  parameter int Slide = 0
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [Width-1:0] in_data,
  output logic                    in_ready,
  input  logic                    flush,
  input  logic                    frame_ack,
  output logic                    sr_enable,
  output logic signed [Width-1:0] sr_data,
  output logic                    sr_clear,
  output logic                    frame_valid,
  output logic [FILL_W-1:0]       fill_count,
  output logic [CNT_W-1:0]        frame_cnt
);

  localparam logic [FILL_W-1:0] DEPTH_F  = FILL_W'(Depth);
  localparam logic [FILL_W-1:0] DEPTH_M1 = FILL_W'(Depth - 1);
  localparam logic [FILL_W-1:0] ACK_FILL = fill_after_ack(Depth, Slide);

  logic [1:0]        state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              accept;

  assign in_ready  = (state_q == LOAD) && !flush;
  assign accept    = in_valid && in_ready;
  // The tap register captures on the same edge the controller counts the sample.
  assign sr_enable = accept;
  assign sr_data   = in_data;

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    frame_cnt_d = frame_cnt_q;
    if (flush) begin
      state_d = CLEAR;
      fill_d  = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            if (fill_q == DEPTH_M1) begin
              state_d = FULL;
              fill_d  = DEPTH_F;
            end else begin
              fill_d = fill_q + 1'b1;
            end
          end
        end
        FULL: begin
          if (frame_ack) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            fill_d      = ACK_FILL;
            state_d     = (Slide != 0) ? LOAD : CLEAR;
          end
        end
        CLEAR: begin
          state_d = LOAD;
          fill_d  = '0;
        end
        default: begin
          state_d = CLEAR;
          fill_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= CLEAR;
      fill_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sr_clear    = (state_q == CLEAR);
  assign frame_valid = (state_q == FULL);
  assign fill_count  = fill_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
